pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports: clk, in, 1, pipeline clock; rst_n, in, 1, reset, asynchronous, active-low.
REQ-002 The block SHALL have these ID-stage inputs: id_rs1 in 5 and id_rs2 in 5 (source register indices); id_rs1_used in 1 and id_rs2_used in 1 (the operand is read).
REQ-003 The block SHALL have these EX-stage inputs: ex_rd in 5, destination register; ex_wen in 1, writes rd; ex_is_load in 1, load instruction; ex_redirect in 1, taken branch/jump; ex_redirect_pc in 64, target.
REQ-004 The block SHALL have this input: mem_busy, in, 1, data memory not ready, so the whole pipe freezes.
REQ-005 The block SHALL have these outputs, all 1 bit: pc_stall, if_id_stall, if_id_flush (load NOP 32'h0000_0013), id_ex_stall, id_ex_bubble, ex_mem_stall, pc_redirect_en.
REQ-006 The block SHALL have this output: pc_redirect_val, out, 64.

Function
REQ-007 The block SHALL hold a registered state in {RUN, FLUSH2, MEMWAIT}, plus a pending-redirect flag pend_v and a 64-bit register pend_pc.
REQ-008 All outputs SHALL be combinational from the registered state and the current inputs, with zero-cycle latency.
REQ-009 Priority SHALL be: mem_busy > redirect > load-use.
REQ-010 A load-use hazard SHALL be defined as ex_is_load & ex_wen & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-011 In RUN with mem_busy=1, the block SHALL assert pc_stall, if_id_stall, id_ex_stall and ex_mem_stall, and go to MEMWAIT.
REQ-012 If ex_redirect=1 in that same cycle, the block SHALL set pend_v=1 and pend_pc=ex_redirect_pc, and SHALL NOT assert pc_redirect_en.
REQ-013 In MEMWAIT, the block SHALL keep all four stalls asserted while mem_busy=1.
REQ-014 In MEMWAIT, when mem_busy falls with pend_v=1, the block SHALL drive pc_redirect_en=1, pc_redirect_val=pend_pc, if_id_flush=1 and id_ex_bubble=1, clear pend_v, and go to FLUSH2.
REQ-015 In MEMWAIT, when mem_busy falls with pend_v=0, the block SHALL go to RUN with no stall asserted in that cycle.
REQ-016 In RUN with ex_redirect=1 and mem_busy=0, the block SHALL drive pc_redirect_en=1, pc_redirect_val=ex_redirect_pc, if_id_flush=1 and id_ex_bubble=1, and go to FLUSH2.
REQ-017 In FLUSH2 with mem_busy=0, the block SHALL assert if_id_flush only, squashing the one-cycle-latency fetch, and go to RUN.
REQ-018 In FLUSH2, ex_redirect SHALL be ignored because EX holds a bubble.
REQ-019 In FLUSH2 with mem_busy=1, the block SHALL assert the stalls without the flush, go to MEMWAIT, and re-enter FLUSH2 when mem_busy falls.
REQ-020 In RUN with a load-use hazard and neither mem_busy nor redirect, the block SHALL assert pc_stall, if_id_stall and id_ex_bubble for exactly one cycle and remain in RUN.
REQ-021 A load-use hazard in the same cycle as ex_redirect SHALL be suppressed.
REQ-022 pc_redirect_val SHALL be 64'h0 whenever pc_redirect_en=0.
REQ-023 if_id_flush and if_id_stall SHALL never be asserted together.

Reset
REQ-024 While rst_n=0, the state SHALL be RUN, pend_v=0, pend_pc=0, and every output SHALL be 0.
REQ-025 Reset asserted mid-MEMWAIT or mid-FLUSH2 SHALL discard any pending redirect.
REQ-026 After rst_n rises, normal operation SHALL begin at the next clk edge.

Configuration
REQ-027 With macro HAZ_PERF_CNT_EN defined, the block SHALL add outputs perf_stall_cnt out 32 and perf_flush_cnt out 32.
REQ-028 perf_stall_cnt SHALL increment in each cycle pc_stall=1; perf_flush_cnt SHALL increment in each cycle if_id_flush=1.
REQ-029 Both counters SHALL saturate at 32'hFFFF_FFFF and reset to 0.
REQ-030 Without HAZ_PERF_CNT_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 The state encoding localparams and the NOP constant 32'h0000_0013 SHALL reside in the shared defines/package used by the pipeline registers.
REQ-032 Load-use comparison SHALL be a combinational sub-module haz_ldu_detect, instantiated once.

Verification
REQ-033 Redirect: ex_redirect=1, ex_redirect_pc=64'h8000_0040 in RUN -> cycle0: pc_redirect_en=1, val=64'h8000_0040, if_id_flush=1, id_ex_bubble=1; cycle1: if_id_flush=1 only; cycle2: all 0.
REQ-034 Load-use: ex_is_load=1, ex_wen=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_stall, if_id_stall and id_ex_bubble high for 1 cycle; ex_rd=0 -> no stall.
REQ-035 Mem wait with pending redirect: mem_busy=1 for 3 cycles with ex_redirect=1, pc=64'h8000_0100 in the first cycle -> 3 cycles all stalls high and pc_redirect_en=0; next cycle pc_redirect_en=1, val=64'h8000_0100; then FLUSH2.
REQ-036 Simultaneous events: redirect plus load-use in the same cycle -> redirect only, no if_id_stall; redirect in FLUSH2 -> ignored.
REQ-037 Reset mid-MEMWAIT: pend_v=1, rst_n low 1 cycle -> all outputs 0 and no later redirect.
REQ-038 HAZ_PERF_CNT_EN defined: 4 load-use stalls and 1 redirect -> perf_stall_cnt=4, perf_flush_cnt=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared hazard-control state encodings and pipeline NOP constant
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0]  HAZ_ST_RUN     = 2'd0;
  localparam logic [1:0]  HAZ_ST_FLUSH2  = 2'd1;
  localparam logic [1:0]  HAZ_ST_MEMWAIT = 2'd2;

  // Instruction loaded into IF/ID when it is flushed (addi x0, x0, 0).
  localparam logic [31:0] HAZ_NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN     = HAZ_ST_RUN,
    ST_FLUSH2  = HAZ_ST_FLUSH2,
    ST_MEMWAIT = HAZ_ST_MEMWAIT
  } haz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_ldu_detect.sv
// rtl/pipe_hazard_ctrl_ldu_detect.sv - combinational load-use hazard comparator (module haz_ldu_detect)
module haz_ldu_detect (
  input  logic       ex_is_load,
  input  logic       ex_wen,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
  // x0 is never really written, so a load targeting it cannot create a hazard.
  assign hazard  = ex_is_load && ex_wen && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/redirect control; HAZ_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic [63:0] ex_redirect_pc,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        ex_mem_stall,
  output logic        pc_redirect_en,
  output logic [63:0] pc_redirect_val
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  haz_state_e  state;
  haz_state_e  nxt_state;
  logic        pend_v;
  logic        nxt_pend_v;
  logic [63:0] pend_pc;
  logic [63:0] nxt_pend_pc;
  logic        ret_flush;
  logic        nxt_ret_flush;
  logic        ldu_hazard;

  haz_ldu_detect u_ldu (
    .ex_is_load  (ex_is_load),
    .ex_wen      (ex_wen),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .hazard      (ldu_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      pend_v    <= 1'b0;
      pend_pc   <= 64'h0;
      ret_flush <= 1'b0;
    end else begin
      state     <= nxt_state;
      pend_v    <= nxt_pend_v;
      pend_pc   <= nxt_pend_pc;
      ret_flush <= nxt_ret_flush;
    end
  end

  always_comb begin
    nxt_state       = state;
    nxt_pend_v      = pend_v;
    nxt_pend_pc     = pend_pc;
    nxt_ret_flush   = ret_flush;
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_bubble    = 1'b0;
    ex_mem_stall    = 1'b0;
    pc_redirect_en  = 1'b0;
    pc_redirect_val = 64'h0;

    unique case (state)
      ST_RUN: begin
        if (mem_busy) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          nxt_state     = ST_MEMWAIT;
          nxt_ret_flush = 1'b0;
          // The frozen branch is remembered and redirected once memory is ready.
          if (ex_redirect) begin
            nxt_pend_v  = 1'b1;
            nxt_pend_pc = ex_redirect_pc;
          end
        end else if (ex_redirect) begin
          pc_redirect_en  = 1'b1;
          pc_redirect_val = ex_redirect_pc;
          if_id_flush     = 1'b1;
          id_ex_bubble    = 1'b1;
          nxt_state       = ST_FLUSH2;
        end else if (ldu_hazard) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        if (mem_busy) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end else if (pend_v) begin
          pc_redirect_en  = 1'b1;
          pc_redirect_val = pend_pc;
          if_id_flush     = 1'b1;
          id_ex_bubble    = 1'b1;
          nxt_pend_v      = 1'b0;
          nxt_pend_pc     = 64'h0;
          nxt_state       = ST_FLUSH2;
        end else if (ret_flush) begin
          // The wait interrupted a FLUSH2 whose squash has not happened yet.
          nxt_ret_flush = 1'b0;
          nxt_state     = ST_FLUSH2;
        end else begin
          nxt_state = ST_RUN;
        end
      end

      ST_FLUSH2: begin
        if (mem_busy) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          nxt_ret_flush = 1'b1;
          nxt_state     = ST_MEMWAIT;
        end else begin
          if_id_flush = 1'b1;
          nxt_state   = ST_RUN;
        end
      end

      default: begin
        nxt_state = ST_RUN;
      end
    endcase

    if (!rst_n) begin
      pc_stall        = 1'b0;
      if_id_stall     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_stall     = 1'b0;
      id_ex_bubble    = 1'b0;
      ex_mem_stall    = 1'b0;
      pc_redirect_en  = 1'b0;
      pc_redirect_val = 64'h0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (pc_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (if_id_flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  // Output vector bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, pc_redirect_en
  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_STALL = 7'b110_1010;
  localparam logic [6:0] O_REDIR = 7'b001_0101;
  localparam logic [6:0] O_FLUSH = 7'b001_0000;
  localparam logic [6:0] O_LDU   = 7'b110_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_wen, ex_is_load, ex_redirect, mem_busy;
  logic [63:0] ex_redirect_pc;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, pc_redirect_en;
  logic [63:0] pc_redirect_val;
  logic [6:0]  outs;
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_wen          (ex_wen),
    .ex_is_load      (ex_is_load),
    .ex_redirect     (ex_redirect),
    .ex_redirect_pc  (ex_redirect_pc),
    .mem_busy        (mem_busy),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_stall    (ex_mem_stall),
    .pc_redirect_en  (pc_redirect_en),
    .pc_redirect_val (pc_redirect_val)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, pc_redirect_en};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [6:0] exp_o, input logic [63:0] exp_val);
    #2;
    check({tag, "_outs"}, {57'h0, outs}, {57'h0, exp_o});
    check({tag, "_val"}, pc_redirect_val, exp_val);
    check({tag, "_excl"}, {63'h0, if_id_flush & if_id_stall}, 64'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_wen = 1'b0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; ex_redirect_pc = 64'h0; mem_busy = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = rd; id_rs1 = rd; id_rs1_used = 1'b1;
  endtask

  task automatic redirect(input logic [63:0] pc);
    ex_redirect = 1'b1; ex_redirect_pc = pc;
  endtask

  initial begin
    idle_inputs();
    // Reset with active-looking inputs: every output must still be zero.
    redirect(64'h8000_0040); load_use(5'd3);
    step(); expect_outs("rst_hold", O_NONE, 64'h0);
    step(); rst_n = 1'b1; idle_inputs(); expect_outs("rst_rel", O_NONE, 64'h0);

    step(); redirect(64'h8000_0040); expect_outs("redir_c0", O_REDIR, 64'h8000_0040);
    step(); idle_inputs(); expect_outs("redir_c1", O_FLUSH, 64'h0);
    step(); expect_outs("redir_c2", O_NONE, 64'h0);

    step(); load_use(5'd5); expect_outs("ldu_rs1", O_LDU, 64'h0);
    step(); idle_inputs(); expect_outs("ldu_after", O_NONE, 64'h0);
    step(); load_use(5'd0); expect_outs("ldu_x0", O_NONE, 64'h0);
    step(); idle_inputs(); ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9;
    expect_outs("ldu_rs2_unused", O_NONE, 64'h0);
    step(); id_rs2_used = 1'b1; expect_outs("ldu_rs2", O_LDU, 64'h0);
    step(); ex_is_load = 1'b0; expect_outs("ldu_notload", O_NONE, 64'h0);

    step(); idle_inputs(); mem_busy = 1'b1; redirect(64'h8000_0100);
    expect_outs("mw_c0", O_STALL, 64'h0);
    step(); idle_inputs(); mem_busy = 1'b1; expect_outs("mw_c1", O_STALL, 64'h0);
    step(); expect_outs("mw_c2", O_STALL, 64'h0);
    step(); mem_busy = 1'b0; expect_outs("mw_redir", O_REDIR, 64'h8000_0100);
    step(); expect_outs("mw_flush2", O_FLUSH, 64'h0);
    step(); expect_outs("mw_done", O_NONE, 64'h0);

    step(); redirect(64'h8000_0200); load_use(5'd7); expect_outs("sim_redir_ldu", O_REDIR, 64'h8000_0200);
    step(); idle_inputs(); redirect(64'h8000_0300); expect_outs("sim_f2_ignore", O_FLUSH, 64'h0);
    step(); idle_inputs(); expect_outs("sim_done", O_NONE, 64'h0);

    step(); mem_busy = 1'b1; expect_outs("mwnp_busy", O_STALL, 64'h0);
    step(); mem_busy = 1'b0; load_use(5'd4); expect_outs("mwnp_fall", O_NONE, 64'h0);
    step(); expect_outs("mwnp_run_ldu", O_LDU, 64'h0);
    step(); idle_inputs(); expect_outs("mwnp_done", O_NONE, 64'h0);

    step(); redirect(64'h8000_0400); expect_outs("f2mw_redir", O_REDIR, 64'h8000_0400);
    step(); idle_inputs(); mem_busy = 1'b1; expect_outs("f2mw_busy", O_STALL, 64'h0);
    step(); mem_busy = 1'b0; #2;
    check("f2mw_fall_stalls", {57'h0, outs & O_STALL}, 64'h0);
    step(); expect_outs("f2mw_reflush", O_FLUSH, 64'h0);
    step(); expect_outs("f2mw_done", O_NONE, 64'h0);

    step(); mem_busy = 1'b1; redirect(64'h8000_0500); expect_outs("rstmw_busy", O_STALL, 64'h0);
    step(); idle_inputs(); mem_busy = 1'b1; #1; rst_n = 1'b0; expect_outs("rstmw_async", O_NONE, 64'h0);
    step(); rst_n = 1'b1; mem_busy = 1'b0; expect_outs("rstmw_rel", O_NONE, 64'h0);
    step(); expect_outs("rstmw_noredir", O_NONE, 64'h0);
    step(); expect_outs("rstmw_noredir2", O_NONE, 64'h0);

    // Four separated load-use stalls followed by one redirect.
    for (int i = 0; i < 4; i++) begin
      step(); load_use(5'd1 + 5'(i)); expect_outs("perf_ldu", O_LDU, 64'h0);
      step(); idle_inputs(); expect_outs("perf_gap", O_NONE, 64'h0);
    end
    step(); redirect(64'h8000_0600); expect_outs("perf_redir", O_REDIR, 64'h8000_0600);
    step(); idle_inputs(); expect_outs("perf_f2", O_FLUSH, 64'h0);
    step(); expect_outs("perf_idle", O_NONE, 64'h0);
`ifdef HAZ_PERF_CNT_EN
    check("perf_stall_cnt", {32'h0, perf_stall_cnt}, 64'd4);
    check("perf_flush_cnt", {32'h0, perf_flush_cnt}, 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
